// File: rtl/ray_dispatcher.sv
// Raster-scanning ray source: issues one ray per cycle to the lowest-index idle ray unit.
// Optional RAY_DISPATCH_STATS_EN adds frameCycles/stallCycles counters.
module ray_dispatcher #(
  parameter int unsigned POSITION_WIDTH = 16,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned IMG_W          = 320,
  parameter int unsigned IMG_H          = 240,
  parameter int unsigned PIXEL_BYTES    = 4
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    frameStart,
  output logic                                    frameBusy,
  output logic                                    frameDone,
  input  logic [3*POSITION_WIDTH-1:0]             camQ,
  input  logic [3*POSITION_WIDTH-1:0]             dirCorner,
  input  logic [3*POSITION_WIDTH-1:0]             dirDx,
  input  logic [3*POSITION_WIDTH-1:0]             dirDy,
  input  logic [ADDRESS_WIDTH-1:0]                frameBase,
  output logic                                    unitFlush,
  output logic [NUM_UNITS-1:0]                    unitStart,
  input  logic [NUM_UNITS-1:0]                    unitBusy,
  output logic [NUM_UNITS*3*POSITION_WIDTH-1:0]   unitRayQ,
  output logic [NUM_UNITS*3*POSITION_WIDTH-1:0]   unitRayV,
  output logic [NUM_UNITS*ADDRESS_WIDTH-1:0]      unitPixelAddr
`ifdef RAY_DISPATCH_STATS_EN
  ,
  output logic [31:0]                             frameCycles,
  output logic [31:0]                             stallCycles
`endif
);

  localparam int unsigned VW = 3 * POSITION_WIDTH;
  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t                   state;
  logic [XW-1:0]            x;
  logic [YW-1:0]            y;
  logic [VW-1:0]            cam_q;
  logic [VW-1:0]            dir_dx;
  logic [VW-1:0]            dir_dy;
  logic [VW-1:0]            v_row;
  logic [VW-1:0]            v_pix;
  logic [ADDRESS_WIDTH-1:0] addr;

  logic [NUM_UNITS-1:0]     free;
  logic [NUM_UNITS-1:0]     pick;
  logic                     found;
  logic                     row_end;
  logic                     last_pixel;

  // Component-wise add; each lane wraps independently.
  function automatic logic [VW-1:0] vec_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      r[c*POSITION_WIDTH +: POSITION_WIDTH] =
        a[c*POSITION_WIDTH +: POSITION_WIDTH] + b[c*POSITION_WIDTH +: POSITION_WIDTH];
    end
    return r;
  endfunction

  // A unit whose start is still asserted has not yet raised busy, so it is not free.
  always_comb begin
    free  = ~unitBusy & ~unitStart;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (free[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign row_end    = (x == XW'(IMG_W - 1));
  assign last_pixel = row_end && (y == YW'(IMG_H - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      frameBusy     <= 1'b0;
      frameDone     <= 1'b0;
      unitFlush     <= 1'b0;
      unitStart     <= '0;
      unitRayQ      <= '0;
      unitRayV      <= '0;
      unitPixelAddr <= '0;
      x             <= '0;
      y             <= '0;
      cam_q         <= '0;
      dir_dx        <= '0;
      dir_dy        <= '0;
      v_row         <= '0;
      v_pix         <= '0;
      addr          <= '0;
    end else begin
      unitFlush <= 1'b0;
      unitStart <= '0;
      frameDone <= 1'b0;
      case (state)
        IDLE: begin
          if (frameStart) begin
            cam_q     <= camQ;
            dir_dx    <= dirDx;
            dir_dy    <= dirDy;
            v_row     <= dirCorner;
            v_pix     <= dirCorner;
            addr      <= frameBase;
            x         <= '0;
            y         <= '0;
            unitFlush <= 1'b1;
            frameBusy <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (found) begin
            unitStart <= pick;
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
              if (pick[i]) begin
                unitRayQ[i*VW +: VW]                        <= cam_q;
                unitRayV[i*VW +: VW]                        <= v_pix;
                unitPixelAddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] <= addr;
              end
            end
            addr <= addr + ADDRESS_WIDTH'(PIXEL_BYTES);
            if (row_end) begin
              x     <= '0;
              y     <= y + YW'(1);
              v_row <= vec_add(v_row, dir_dy);
              v_pix <= vec_add(v_row, dir_dy);
            end else begin
              x     <= x + XW'(1);
              v_pix <= vec_add(v_pix, dir_dx);
            end
            if (last_pixel) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last start pulse is still visible on entry, covering the busy-rise delay.
          if (unitStart == '0 && unitBusy == '0) begin
            frameDone <= 1'b1;
            frameBusy <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RAY_DISPATCH_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      frameCycles <= '0;
      stallCycles <= '0;
    end else if (state == IDLE && frameStart) begin
      frameCycles <= '0;
      stallCycles <= '0;
    end else begin
      if ((state == SCAN || state == DRAIN) && frameCycles != '1)
        frameCycles <= frameCycles + 32'd1;
      if (state == SCAN && !found && stallCycles != '1)
        stallCycles <= stallCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench: a 1-unit and a 4-unit dispatcher on a 4x2 image, each driving a 3-cycle unit model.
module tb_ray_dispatcher;

  localparam logic [47:0] CAM1  = 48'h0003_0002_0001;
  localparam logic [47:0] CAM4  = 48'h0A0A_0B0B_0C0C;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam logic [31:0] BASE4 = 32'h8000_0040;

  logic         clock = 1'b0;
  logic         reset;
  logic         fs1, fs4;
  logic [47:0]  camQ, dirCorner, dirDx, dirDy;
  logic [31:0]  frameBase;

  logic         busy1, done1, flush1;
  logic [0:0]   start1, ubusy1;
  logic [47:0]  rq1, rv1;
  logic [31:0]  pa1;

  logic         busy4, done4, flush4;
  logic [3:0]   start4, ubusy4;
  logic [191:0] rq4, rv4;
  logic [127:0] pa4;

`ifdef RAY_DISPATCH_STATS_EN
  logic [31:0]  fc1, sc1, fc4, sc4;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  ray_dispatcher #(
    .POSITION_WIDTH(16), .ADDRESS_WIDTH(32), .NUM_UNITS(1),
    .IMG_W(4), .IMG_H(2), .PIXEL_BYTES(4)
  ) dut1 (
    .clock(clock), .reset(reset), .frameStart(fs1),
    .frameBusy(busy1), .frameDone(done1),
    .camQ(camQ), .dirCorner(dirCorner), .dirDx(dirDx), .dirDy(dirDy),
    .frameBase(frameBase), .unitFlush(flush1), .unitStart(start1),
    .unitBusy(ubusy1), .unitRayQ(rq1), .unitRayV(rv1), .unitPixelAddr(pa1)
`ifdef RAY_DISPATCH_STATS_EN
    , .frameCycles(fc1), .stallCycles(sc1)
`endif
  );

  ray_dispatcher #(
    .POSITION_WIDTH(16), .ADDRESS_WIDTH(32), .NUM_UNITS(4),
    .IMG_W(4), .IMG_H(2), .PIXEL_BYTES(4)
  ) dut4 (
    .clock(clock), .reset(reset), .frameStart(fs4),
    .frameBusy(busy4), .frameDone(done4),
    .camQ(camQ), .dirCorner(dirCorner), .dirDx(dirDx), .dirDy(dirDy),
    .frameBase(frameBase), .unitFlush(flush4), .unitStart(start4),
    .unitBusy(ubusy4), .unitRayQ(rq4), .unitRayV(rv4), .unitPixelAddr(pa4)
`ifdef RAY_DISPATCH_STATS_EN
    , .frameCycles(fc4), .stallCycles(sc4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ray unit model: busy rises the cycle after start and stays up for 3 cycles.
  logic [1:0] cnt1;
  logic [1:0] cnt4 [4];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      cnt1 <= 2'd0;
      for (int i = 0; i < 4; i++) cnt4[i] <= 2'd0;
    end else begin
      if (start1[0]) cnt1 <= 2'd3;
      else if (cnt1 != 2'd0) cnt1 <= cnt1 - 2'd1;
      for (int i = 0; i < 4; i++) begin
        if (start4[i]) cnt4[i] <= 2'd3;
        else if (cnt4[i] != 2'd0) cnt4[i] <= cnt4[i] - 2'd1;
      end
    end
  end

  assign ubusy1[0] = (cnt1 != 2'd0);
  always_comb begin
    ubusy4 = '0;
    for (int i = 0; i < 4; i++) ubusy4[i] = (cnt4[i] != 2'd0);
  end

  // Stream monitors: every issued ray must carry the next raster pixel.
  int   k1 = 0, falls1 = 0, flushes1 = 0, dones1 = 0, last_fall1 = 0;
  logic prev_busy1 = 1'b0;
  int   k4 = 0, first4 = 0;
  logic [3:0] prev4 = '0;

  always @(negedge clock) begin
    logic [47:0] ev;
    int u;
    if (flush1) begin k1 = 0; falls1 = 0; flushes1++; end
    if (done1) dones1++;
    if (start1[0]) begin
      ev = {16'h0000, 16'(k1 / 4), 16'(k1 % 4)};
      check("d1_addr", pa1, BASE1 + 32'(4 * k1));
      check("d1_dir", rv1, ev);
      check("d1_org", rq1, CAM1);
      k1++;
    end
    if (prev_busy1 && !ubusy1[0]) begin falls1++; last_fall1 = cyc; end
    prev_busy1 = ubusy1[0];

    if (flush4) begin k4 = 0; first4 = cyc; end
    if (start4 != 4'b0) begin
      u = 0;
      for (int i = 3; i >= 0; i--) if (start4[i]) u = i;
      check("d4_onehot", 64'($onehot0(start4)), 64'd1);
      check("d4_repeat", start4 & prev4, 64'd0);
      if (k4 < 4) begin
        check("d4_unit", start4, 64'(4'b0001 << k4));
        check("d4_consec", 64'(cyc - first4), 64'(k4 + 1));
      end
      ev = {16'h0100 + 16'(5 * (k4 / 4)), 16'h0010, 16'((k4 % 4) * 32'hFFFF)};
      check("d4_addr", pa4[u*32 +: 32], BASE4 + 32'(4 * k4));
      check("d4_dir", rv4[u*48 +: 48], ev);
      check("d4_org", rq4[u*48 +: 48], CAM4);
      if (k4 == 2) check("d4_wrap_x", rv4[u*48 +: 16], 16'hFFFE);
      k4++;
    end
    prev4 = start4;
  end

  initial begin
    logic got;
    reset = 1'b1; fs1 = 1'b0; fs4 = 1'b0;
    camQ = '0; dirCorner = '0; dirDx = '0; dirDy = '0; frameBase = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", {busy1, busy4}, 2'b00);
    check("rst_done", {done1, done4}, 2'b00);
    check("rst_flush", {flush1, flush4}, 2'b00);
    check("rst_start", {start1, start4}, 5'b0);
    check("rst_regs", {rq4[63:0] | rv4[63:0], pa4[63:0]} , '0);
    reset = 1'b0;

    // Frame on the single-unit dispatcher; inputs scrambled after accept.
    camQ = CAM1; dirCorner = '0; dirDx = 48'h0000_0000_0001; dirDy = 48'h0000_0001_0000;
    frameBase = BASE1; flushes1 = 0; dones1 = 0;
    @(negedge clock); fs1 = 1'b1;
    @(negedge clock); fs1 = 1'b0;
    camQ = '1; dirDx = '1; dirDy = '1; frameBase = '1;
    check("d1_flush", flush1, 1'b1);
    check("d1_busy", busy1, 1'b1);
    check("d1_nostart_on_flush", start1, 1'b0);
    repeat (10) @(negedge clock);
    fs1 = 1'b1;
    @(negedge clock); fs1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      if (done1) got = 1'b1;
    end
    check("d1_done_seen", got, 1'b1);
    check("d1_busy_at_done", busy1, 1'b0);
    check("d1_ray_count", 64'(k1), 64'd8);
    check("d1_busy_falls", 64'(falls1), 64'd8);
    check("d1_done_latency", 64'(cyc - last_fall1), 64'd1);
`ifdef RAY_DISPATCH_STATS_EN
    // 5 cycles per ray, 4 stalled each between rays; last busy clears 5 cycles after final start.
    check("d1_frame_cycles", fc1, 32'd41);
    check("d1_stall_cycles", sc1, 32'd28);
`endif
    fs1 = 1'b1;
    @(negedge clock); fs1 = 1'b0;
    check("d1_done_start_ignored", {flush1, busy1, done1}, 3'b000);
    repeat (4) @(negedge clock);
    check("d1_done_once", 64'(dones1), 64'd1);
    check("d1_flush_once", 64'(flushes1), 64'd1);

    // Frame on the four-unit dispatcher with wrapping x delta.
    camQ = CAM4; dirCorner = 48'h0100_0010_0000; dirDx = 48'h0000_0000_FFFF;
    dirDy = 48'h0005_0000_0000; frameBase = BASE4;
    fs4 = 1'b1;
    @(negedge clock); fs4 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      if (done4) got = 1'b1;
    end
    check("d4_done_seen", got, 1'b1);
    check("d4_ray_count", 64'(k4), 64'd8);
    check("d4_busy_at_done", busy4, 1'b0);

    // Abort mid-scan with reset, then restart from pixel (0,0).
    repeat (2) @(negedge clock);
    fs4 = 1'b1;
    @(negedge clock); fs4 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (k4 >= 2) got = 1'b1;
    end
    check("d4_progress", got, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_ctrl", {busy4, done4, flush4, start4}, 7'b0);
    check("abort_q", rq4[191:128] | rq4[127:64] | rq4[63:0], 64'd0);
    check("abort_v", rv4[191:128] | rv4[127:64] | rv4[63:0], 64'd0);
    check("abort_addr", pa4[127:64] | pa4[63:0], 64'd0);
    reset = 1'b0;
    @(negedge clock); fs4 = 1'b1;
    @(negedge clock); fs4 = 1'b0;
    check("restart_flush", flush4, 1'b1);
    check("restart_busy", busy4, 1'b1);
    @(negedge clock);
    check("restart_first_unit", start4, 4'b0001);
    check("restart_first_addr", pa4[31:0], BASE4);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      if (done4) got = 1'b1;
    end
    check("restart_done_seen", got, 1'b1);
    check("restart_ray_count", 64'(k4), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
